// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// FSM state encodings, datapath select encodings and the decoded
// instruction-class record.
package mips_pkg;

  // Primary opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes, IR[5:0]
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // FSM states; 5..7 are illegal and recover to FETCH
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // ALU operation
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;

  // Immediate extension
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // Write-back source
  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_LUI   = 2'b10;
  localparam logic [1:0] WB_PC4   = 2'b11;

  // Destination register select
  localparam logic [1:0] WR_RT    = 2'b00;
  localparam logic [1:0] WR_RD    = 2'b01;
  localparam logic [1:0] WR_RA    = 2'b10;

  // Next-PC select
  localparam logic [1:0] JMP_SEQ  = 2'b00;
  localparam logic [1:0] JMP_TGT  = 2'b01;
  localparam logic [1:0] JMP_REG  = 2'b10;

  // One-hot instruction class produced by mc_decode
  typedef struct packed {
    logic rtype_add;
    logic rtype_sub;
    logic jr;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic jal;
    logic unknown;
  } insn_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct classifier for the multi-cycle controller.
// Ports: opcode/funct in (IR fields); cls out (one-hot instruction class,
// exactly one bit set, 'unknown' for anything unsupported).
module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output insn_class_t cls
);

  always_comb begin
    cls = '0;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADDU: cls.rtype_add = 1'b1;
          FN_SUBU: cls.rtype_sub = 1'b1;
          FN_JR:   cls.jr        = 1'b1;
          default: cls.unknown   = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori     = 1'b1;
      OP_LW:   cls.lw      = 1'b1;
      OP_SW:   cls.sw      = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      OP_LUI:  cls.lui     = 1'b1;
      OP_J:    cls.j       = 1'b1;
      OP_JAL:  cls.jal     = 1'b1;
      default: cls.unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer driving
// datapath selects and write enables, plus a retired-instruction counter.
// Ports: clk, reset (sync, active-high); opcode/funct/zero/mem_ready in;
// enables PCWr/IRWr/RegWr/MemWr/MemRd, selects WriteRegDist/ALUSrc/MemtoReg/
// Jump/Branch/ALUOp/ExtOp out (combinational); state/retired out (registered).
module mc_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RegWr,
  output logic             MemWr,
  output logic             MemRd,
  output logic [1:0]       WriteRegDist,
  output logic             ALUSrc,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       Jump,
  output logic             Branch,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ExtOp,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  insn_class_t      cls;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Counter wraps naturally at 2^CNT_W.
  assign retired_d = retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;

  // Registered outputs are still forced to zero while reset is held.
  assign state   = reset ? 3'd0 : state_q;
  assign retired = reset ? '0   : retired_q;

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    PCWr         = 1'b0;
    IRWr         = 1'b0;
    RegWr        = 1'b0;
    MemWr        = 1'b0;
    MemRd        = 1'b0;
    WriteRegDist = WR_RT;
    ALUSrc       = 1'b0;
    MemtoReg     = WB_ALU;
    Jump         = JMP_SEQ;
    Branch       = 1'b0;
    ALUOp        = ALU_ADD;
    ExtOp        = EXT_ZERO;

    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          // Read request stays up while memory stalls; PC/IR update only
          // on the ready cycle.
          MemRd = 1'b1;
          if (mem_ready) begin
            IRWr    = 1'b1;
            PCWr    = 1'b1;
            state_d = S_DECODE;
          end
        end

        S_DECODE: begin
          if (cls.j) begin
            PCWr    = 1'b1;
            Jump    = JMP_TGT;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else if (cls.jal) begin
            // PC+4 was already written in FETCH, so $ra gets the link
            // address while PC takes the jump target in the same cycle.
            PCWr         = 1'b1;
            Jump         = JMP_TGT;
            RegWr        = 1'b1;
            WriteRegDist = WR_RA;
            MemtoReg     = WB_PC4;
            retire       = 1'b1;
            state_d      = S_FETCH;
          end else if (cls.jr) begin
            PCWr    = 1'b1;
            Jump    = JMP_REG;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else if (cls.unknown) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end

        S_EXEC: begin
          if (cls.rtype_add || cls.rtype_sub) begin
            ALUOp   = cls.rtype_sub ? ALU_SUB : ALU_ADD;
            state_d = S_WB;
          end else if (cls.ori) begin
            ALUSrc  = 1'b1;
            ExtOp   = EXT_ZERO;
            ALUOp   = ALU_OR;
            state_d = S_WB;
          end else if (cls.lui) begin
            ExtOp   = EXT_LUI;
            state_d = S_WB;
          end else if (cls.lw || cls.sw) begin
            ALUSrc  = 1'b1;
            ExtOp   = EXT_SIGN;
            ALUOp   = ALU_ADD;
            state_d = S_MEM;
          end else if (cls.beq) begin
            ALUOp   = ALU_SUB;
            Branch  = 1'b1;
            PCWr    = zero;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            // Only reachable if IR fields changed after DECODE; abandon.
            state_d = S_FETCH;
          end
        end

        S_MEM: begin
          if (cls.lw) begin
            MemRd = 1'b1;
            if (mem_ready) state_d = S_WB;
          end else if (cls.sw) begin
            MemWr = 1'b1;
            if (mem_ready) begin
              retire  = 1'b1;
              state_d = S_FETCH;
            end
          end else begin
            state_d = S_FETCH;
          end
        end

        S_WB: begin
          if (cls.rtype_add || cls.rtype_sub) begin
            RegWr        = 1'b1;
            WriteRegDist = WR_RD;
            MemtoReg     = WB_ALU;
          end else if (cls.ori) begin
            RegWr        = 1'b1;
            WriteRegDist = WR_RT;
            MemtoReg     = WB_ALU;
          end else if (cls.lw) begin
            RegWr        = 1'b1;
            WriteRegDist = WR_RT;
            MemtoReg     = WB_MEM;
          end else if (cls.lui) begin
            RegWr        = 1'b1;
            WriteRegDist = WR_RT;
            MemtoReg     = WB_LUI;
          end
          retire  = 1'b1;
          state_d = S_FETCH;
        end

        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode, funct;
  logic          zero, mem_ready;
  logic          PCWr, IRWr, RegWr, MemWr, MemRd, ALUSrc, Branch;
  logic [1:0]    WriteRegDist, MemtoReg, Jump, ALUOp, ExtOp;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr),
    .MemWr(MemWr), .MemRd(MemRd), .WriteRegDist(WriteRegDist),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .Jump(Jump), .Branch(Branch),
    .ALUOp(ALUOp), .ExtOp(ExtOp), .state(state), .retired(retired)
  );

  // {PCWr,IRWr,RegWr,MemWr,MemRd,WriteRegDist,ALUSrc,MemtoReg,Jump,Branch,ALUOp,ExtOp}
  function automatic logic [16:0] c(input logic pc, input logic ir, input logic rw,
                                    input logic mw, input logic mr, input logic [1:0] wrd,
                                    input logic as, input logic [1:0] mtr, input logic [1:0] j,
                                    input logic br, input logic [1:0] aop, input logic [1:0] ext);
    return {pc, ir, rw, mw, mr, wrd, as, mtr, j, br, aop, ext};
  endfunction

  function automatic logic [16:0] ctl_now();
    return {PCWr, IRWr, RegWr, MemWr, MemRd, WriteRegDist, ALUSrc, MemtoReg,
            Jump, Branch, ALUOp, ExtOp};
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic        rst;
    logic [2:0]  st;
    logic [16:0] ctl;
    logic [3:0]  ret;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic rdy, input logic rst, input logic [2:0] st,
                     input logic [16:0] ctl, input logic [3:0] ret);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.rst = rst;
    v.st = st; v.ctl = ctl; v.ret = ret;
    vq.push_back(v);
  endtask

  localparam logic [5:0] R = 6'b000000, ORI = 6'b001101, LW = 6'b100011,
                         SW = 6'b101011, BEQ = 6'b000100, LUI = 6'b001111,
                         J = 6'b000010, JAL = 6'b000011, BAD = 6'b111111;
  localparam logic [5:0] ADDU = 6'b100001, SUBU = 6'b100011, JR = 6'b001000;

  logic [16:0] z0, f_rdy, f_wait, mem_ex, wb_rd;

  initial begin
    z0     = '0;
    f_rdy  = c(1,1,0,0,1,2'd0,0,2'd0,2'd0,0,2'd0,2'd0);
    f_wait = c(0,0,0,0,1,2'd0,0,2'd0,2'd0,0,2'd0,2'd0);
    mem_ex = c(0,0,0,0,0,2'd0,1,2'd0,2'd0,0,2'd0,2'd1);
    wb_rd  = c(0,0,1,0,0,2'd1,0,2'd0,2'd0,0,2'd0,2'd0);

    // reset held: everything zero
    add(SW, 0, 0, 1, 1, 0, z0, 0);
    add(SW, 0, 0, 1, 1, 0, z0, 0);
    // addu
    add(R, ADDU, 0, 1, 0, 0, f_rdy, 0);
    add(R, ADDU, 0, 1, 0, 1, z0, 0);
    add(R, ADDU, 0, 1, 0, 2, z0, 0);
    add(R, ADDU, 0, 1, 0, 4, wb_rd, 0);
    // subu
    add(R, SUBU, 0, 1, 0, 0, f_rdy, 1);
    add(R, SUBU, 0, 1, 0, 1, z0, 1);
    add(R, SUBU, 0, 1, 0, 2, c(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd1,2'd0), 1);
    add(R, SUBU, 0, 1, 0, 4, wb_rd, 1);
    // lw with two MEM wait cycles: 7 cycles
    add(LW, 0, 0, 1, 0, 0, f_rdy, 2);
    add(LW, 0, 0, 1, 0, 1, z0, 2);
    add(LW, 0, 0, 1, 0, 2, mem_ex, 2);
    add(LW, 0, 0, 0, 0, 3, f_wait, 2);
    add(LW, 0, 0, 0, 0, 3, f_wait, 2);
    add(LW, 0, 0, 1, 0, 3, f_wait, 2);
    add(LW, 0, 0, 1, 0, 4, c(0,0,1,0,0,2'd0,0,2'd1,2'd0,0,2'd0,2'd0), 2);
    // ori with one FETCH wait cycle
    add(ORI, 0, 0, 0, 0, 0, f_wait, 3);
    add(ORI, 0, 0, 1, 0, 0, f_rdy, 3);
    add(ORI, 0, 0, 1, 0, 1, z0, 3);
    add(ORI, 0, 0, 1, 0, 2, c(0,0,0,0,0,2'd0,1,2'd0,2'd0,0,2'd2,2'd0), 3);
    add(ORI, 0, 0, 1, 0, 4, c(0,0,1,0,0,2'd0,0,2'd0,2'd0,0,2'd0,2'd0), 3);
    // lui
    add(LUI, 0, 0, 1, 0, 0, f_rdy, 4);
    add(LUI, 0, 0, 1, 0, 1, z0, 4);
    add(LUI, 0, 0, 1, 0, 2, c(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd0,2'd2), 4);
    add(LUI, 0, 0, 1, 0, 4, c(0,0,1,0,0,2'd0,0,2'd2,2'd0,0,2'd0,2'd0), 4);
    // beq taken / not taken
    add(BEQ, 0, 0, 1, 0, 0, f_rdy, 5);
    add(BEQ, 0, 0, 1, 0, 1, z0, 5);
    add(BEQ, 0, 1, 1, 0, 2, c(1,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd1,2'd0), 5);
    add(BEQ, 0, 0, 1, 0, 0, f_rdy, 6);
    add(BEQ, 0, 0, 1, 0, 1, z0, 6);
    add(BEQ, 0, 0, 1, 0, 2, c(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd1,2'd0), 6);
    // jal, jr, j
    add(JAL, 0, 0, 1, 0, 0, f_rdy, 7);
    add(JAL, 0, 0, 1, 0, 1, c(1,0,1,0,0,2'd2,0,2'd3,2'd1,0,2'd0,2'd0), 7);
    add(R, JR, 0, 1, 0, 0, f_rdy, 8);
    add(R, JR, 0, 1, 0, 1, c(1,0,0,0,0,2'd0,0,2'd0,2'd2,0,2'd0,2'd0), 8);
    add(J, 0, 0, 1, 0, 0, f_rdy, 9);
    add(J, 0, 0, 1, 0, 1, c(1,0,0,0,0,2'd0,0,2'd0,2'd1,0,2'd0,2'd0), 9);
    // unknown opcode and unknown R-type funct: retire as nop
    add(BAD, 0, 0, 1, 0, 0, f_rdy, 10);
    add(BAD, 0, 0, 1, 0, 1, z0, 10);
    add(R, 6'b000000, 0, 1, 0, 0, f_rdy, 11);
    add(R, 6'b000000, 0, 1, 0, 1, z0, 11);
    // sw with one MEM wait cycle
    add(SW, 0, 0, 1, 0, 0, f_rdy, 12);
    add(SW, 0, 0, 1, 0, 1, z0, 12);
    add(SW, 0, 0, 1, 0, 2, mem_ex, 12);
    add(SW, 0, 0, 0, 0, 3, c(0,0,0,1,0,2'd0,0,2'd0,2'd0,0,2'd0,2'd0), 12);
    add(SW, 0, 0, 1, 0, 3, c(0,0,0,1,0,2'd0,0,2'd0,2'd0,0,2'd0,2'd0), 12);
    // sw abandoned by reset in MEM
    add(SW, 0, 0, 1, 0, 0, f_rdy, 13);
    add(SW, 0, 0, 1, 0, 1, z0, 13);
    add(SW, 0, 0, 1, 0, 2, mem_ex, 13);
    add(SW, 0, 0, 0, 0, 3, c(0,0,0,1,0,2'd0,0,2'd0,2'd0,0,2'd0,2'd0), 13);
    add(SW, 0, 0, 0, 1, 0, z0, 0);

    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst; opcode = vq[i].op; funct = vq[i].fn;
      zero = vq[i].z; mem_ready = vq[i].rdy;
      #1;
      check("state",   i, 32'(state),     32'(vq[i].st));
      check("ctl",     i, 32'(ctl_now()), 32'(vq[i].ctl));
      check("retired", i, 32'(retired),   32'(vq[i].ret));
    end

    // After the reset above, state must be FETCH with counter cleared;
    // then 16 two-cycle j instructions push retired through 15 and wrap to 0.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      reset = 1'b0; opcode = J; funct = '0; zero = 1'b0; mem_ready = 1'b1;
      #1;
      check("wrap_fetch_state", k, 32'(state), 32'd0);
      check("wrap_fetch_ret",   k, 32'(retired), 32'(k));
      @(negedge clk);
      #1;
      check("wrap_dec_state", k, 32'(state), 32'd1);
      check("wrap_dec_ctl",   k, 32'(ctl_now()),
            32'(c(1,0,0,0,0,2'd0,0,2'd0,2'd1,0,2'd0,2'd0)));
    end
    @(negedge clk);
    #1;
    check("wrap_state", 0, 32'(state), 32'd0);
    check("wrap_ret",   0, 32'(retired), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS datapath. It sequences one shared ALU, a unified instruction/data memory port and the register file through FETCH/DECODE/EXEC/MEM/WB states. It drives every datapath mux select (write-register, ALU B source, write-back source, next-PC) and every architectural write enable. It sits between the instruction register and the datapath muxes and replaces the single-cycle combinational decoder.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU equality flag, sampled in EXEC
- mem_ready  in  1  memory handshake; FETCH/MEM hold until 1
- PCWr  out  1  PC register write enable
- IRWr  out  1  instruction register write enable
- RegWr  out  1  register file write enable
- MemWr  out  1  data memory write enable
- MemRd  out  1  memory read request
- WriteRegDist  out  2  00 Rt, 01 Rd, 10 $ra
- ALUSrc  out  1  0 RData2, 1 extended immediate
- MemtoReg  out  2  00 ALU, 01 Mem, 10 lui ext, 11 PC+4
- Jump  out  2  00 sequential/branch, 01 j/jal target, 10 jr
- Branch  out  1  qualifies zero for beq
- ALUOp  out  2  00 add, 01 sub, 10 or
- ExtOp  out  2  00 zero-ext, 01 sign-ext, 10 lui (imm<<16)
- state  out  3  current state, for debug
- retired  out  CNT_W  count of completed instructions

## Operation
- Supported: addu, subu (opcode 000000, funct 100001/100011), jr (000000/001000), ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011. Anything else: unknown, treated as nop.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5–7 are illegal and go to FETCH.
- FETCH: MemRd=1. When mem_ready=1, assert IRWr=1 and PCWr=1 (Jump=00, Branch=0, PC<=PC+4) and go to DECODE. Otherwise hold with all enables 0.
- DECODE:
  - j: PCWr, Jump=01.
  - jal: PCWr, Jump=01, RegWr, WriteRegDist=10, MemtoReg=11.
  - jr: PCWr, Jump=10.
  - Each of these retires and goes to FETCH. Unknown opcode/funct retires and goes to FETCH with no writes.
  - All others go to EXEC.
- EXEC:
  - R-type: ALUSrc=0, ALUOp per funct; to WB.
  - ori: ALUSrc=1, ExtOp=00, ALUOp=10; to WB.
  - lui: ExtOp=10; to WB.
  - lw/sw: ALUSrc=1, ExtOp=01, ALUOp=00; to MEM.
  - beq: ALUSrc=0, ALUOp=01, Branch=1, PCWr=zero, Jump=00; retires and goes to FETCH.
- MEM:
  - lw: MemRd=1; on mem_ready go to WB.
  - sw: MemWr=1 held until mem_ready, then retire and go to FETCH.
- WB: RegWr=1.
  - R-type: WriteRegDist=01, MemtoReg=00.
  - ori: WriteRegDist=00, MemtoReg=00.
  - lw: WriteRegDist=00, MemtoReg=01.
  - lui: WriteRegDist=00, MemtoReg=10.
  - Retire and go to FETCH.
- Select outputs not listed for a state are 0.
- retired increments by 1 on each retire cycle and wraps modulo 2^CNT_W.

## Timing
- state and retired are registered. All other outputs are combinational from state, opcode, funct, zero and mem_ready. Outputs are glitch-tolerant because enables are sampled at the clock edge.
- With mem_ready tied to 1, cycles per instruction are:
  - j/jal/jr/unknown: 2
  - beq: 3
  - R-type/ori/lui/sw: 4
  - lw: 5
- Each mem_ready=0 cycle in FETCH or MEM adds one cycle. Enables stay deasserted while waiting, except MemRd and MemWr, which stay asserted.
- Reset: while reset=1, every output is 0 regardless of state. The next edge sets state=FETCH and retired=0. Reset mid-instruction abandons it with no further writes.
- opcode/funct must be stable from the DECODE edge until retire; the controller does not latch them.

## Structure
- Shared package mips_pkg holds:
  - opcode/funct constants
  - state encodings
  - ALUOp, ExtOp, MemtoReg, WriteRegDist and Jump encodings
- One sub-module, mc_decode: purely combinational opcode/funct to instruction-class one-hot (rtype_add, rtype_sub, jr, ori, lw, sw, beq, lui, j, jal, unknown). mc_ctrl holds the FSM and output logic.

## Test plan
- addu after reset, mem_ready=1: states 0,1,2,4,0. RegWr=1 only in WB, with WriteRegDist=01 and MemtoReg=00. retired 0 to 1.
- lw with mem_ready=0 for 2 cycles in MEM: takes 7 cycles total. MemRd held; RegWr=1 with MemtoReg=01 only after ready.
- beq with zero=1, then with zero=0: PCWr=1 in EXEC in the first case, PCWr=0 in the second. Both take 3 cycles.
- jal: 2 cycles. In DECODE: PCWr=1, Jump=01, RegWr=1, WriteRegDist=10, MemtoReg=11.
- Opcode 111111: 2 cycles, no RegWr/MemWr, retired increments. Then reset asserted mid-sw in MEM: all outputs 0 and state=FETCH next cycle.
- Preload retired to all-ones, i.e. 2^CNT_W−1 instructions (run with CNT_W=4): wraps to 0.
